// File: rtl/exec_writeback_stage_pkg.sv
// exec_writeback_stage_pkg: shared processor constants.
// Opcode encodings (code_word[17:14]), OP_IF condition codes (code_word[10:8]),
// ALU function codes (code_word[3:0]) and the execute/writeback state enum.
package exec_writeback_stage_pkg;

    localparam logic [3:0] OP_ADD_IMM8         = 4'd0;
    localparam logic [3:0] OP_MOV_IMM11        = 4'd1;
    localparam logic [3:0] OP_MOV_IMM11_TOP    = 4'd2;
    localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'd3;
    localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'd4;
    localparam logic [3:0] OP_ALU              = 4'd5;
    localparam logic [3:0] OP_IF               = 4'd6;
    localparam logic [3:0] OP_CALL_IMM14       = 4'd7;
    localparam logic [3:0] OP_RETURN           = 4'd8;
    localparam logic [3:0] OP_MUL_SHIFT        = 4'd9;
    localparam logic [3:0] OP_WAIT             = 4'd10;

    localparam logic [2:0] IF_ZERO    = 3'd0;
    localparam logic [2:0] IF_NONZERO = 3'd1;
    localparam logic [2:0] IF_NEG     = 3'd2;
    localparam logic [2:0] IF_POS     = 3'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// alu: combinational arithmetic/logic unit.
// Ports: a_i, b_i - operands; op_i - function code (ALU_*); y_o - result.
// Unlisted function codes pass b_i through.
module alu
    import exec_writeback_stage_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_NOT: y_o = ~a_i;
            ALU_SHL: y_o = a_i << 1;
            ALU_SHR: y_o = a_i >> 1;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/exec_writeback_stage_mulxx_pipe.sv
// mulxx_pipe: unsigned multiply-and-shift with a fixed latency.
// Ports: clock, reset (async active-low); start_i - accept pulse, captures
// a_i/b_i/shift_i; wb_o - the stage registers the writeback on this edge;
// done_o - last busy cycle (stage returns to RUN on this edge);
// result_o - low WORD_SIZE bits of (a*b) >> shift.
module mulxx_pipe #(
    parameter int WORD_SIZE   = 18,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [4:0]           shift_i,
    output logic                 wb_o,
    output logic                 done_o,
    output logic [WORD_SIZE-1:0] result_o
);

    localparam logic [3:0] LAT = 4'(MUL_LATENCY);

    logic [3:0]             cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   a_q, b_q, a_s, b_s;
    logic [4:0]             sh_q, sh_s;
    logic [2*WORD_SIZE-1:0] prod, shifted;

    // cnt_q holds the index (1..LAT) of the current MUL cycle, 0 when idle.
    assign done_o  = cnt_q == LAT;
    assign cnt_d   = start_i ? 4'd1 : (cnt_q == 4'd0 || done_o) ? 4'd0 : cnt_q + 4'd1;
    // The writeback flop is loaded one edge before the last MUL cycle so the
    // pulse is visible during it; with LAT==1 that is the accept edge itself.
    assign wb_o    = (LAT == 4'd1) ? start_i : (cnt_q == LAT - 4'd1);

    // Live operands are only needed when the result is due on the accept edge.
    assign a_s      = start_i ? a_i : a_q;
    assign b_s      = start_i ? b_i : b_q;
    assign sh_s     = start_i ? shift_i : sh_q;
    assign prod     = {{WORD_SIZE{1'b0}}, a_s} * {{WORD_SIZE{1'b0}}, b_s};
    assign shifted  = prod >> sh_s;
    assign result_o = shifted[WORD_SIZE-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (start_i) begin
                a_q  <= a_i;
                b_q  <= b_i;
                sh_q <= shift_i;
            end
        end
    end

endmodule

// File: rtl/exec_writeback_stage.sv
// exec_writeback_stage: executes one instruction per accept and produces
// registered register-file writeback and fetch-redirect pulses.
// Ports: clock, reset (async active-low); in_valid/in_ready - instruction
// handshake; alu_data0/alu_data1/data1_plus_imm8/memory_out - operands;
// code_word - instruction (fields in [17:0]); ip/ip_plus_one - addresses;
// wake - ends OP_WAIT; reg_write_* - writeback pulse; jump_* - redirect
// pulse; busy - stage is in MUL or WAIT.
module exec_writeback_stage
    import exec_writeback_stage_pkg::*;
#(
    parameter int ADDR_SIZE   = 18,
    parameter int WORD_SIZE   = 18,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] alu_data0,
    input  logic [WORD_SIZE-1:0] alu_data1,
    input  logic [WORD_SIZE-1:0] data1_plus_imm8,
    input  logic [WORD_SIZE-1:0] memory_out,
    input  logic [WORD_SIZE-1:0] code_word,
    input  logic [ADDR_SIZE-1:0] ip,
    input  logic [ADDR_SIZE-1:0] ip_plus_one,
    input  logic                 wake,
    output logic                 reg_write_enable,
    output logic [2:0]           reg_write_addr,
    output logic [WORD_SIZE-1:0] reg_write_data,
    output logic                 jump_valid,
    output logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic                 we_q, we_d, jv_q, jv_d;
    logic [2:0]           wa_q, wa_d, mul_rx_q;
    logic [WORD_SIZE-1:0] wd_q, wd_d, alu_y, mul_res;
    logic [ADDR_SIZE-1:0] ja_q, ja_d, if_target;
    logic [17:0]          cw;
    logic [3:0]           op;
    logic [2:0]           rx;
    logic                 accept, cond_true, mul_start, mul_wb, mul_done;

    assign cw        = code_word[17:0];
    assign op        = cw[17:14];
    assign rx        = cw[13:11];
    assign in_ready  = state_q == RUN;
    assign busy      = state_q != RUN;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && op == OP_MUL_SHIFT;
    assign if_target = ip + {{(ADDR_SIZE-8){cw[7]}}, cw[7:0]};
    assign cond_true = (cw[10:8] == IF_ZERO)    ? (alu_data0 == '0) :
                       (cw[10:8] == IF_NONZERO) ? (alu_data0 != '0) :
                       (cw[10:8] == IF_NEG)     ?  alu_data0[WORD_SIZE-1] :
                       (cw[10:8] == IF_POS)     ? !alu_data0[WORD_SIZE-1] : 1'b0;

    alu #(.WIDTH(WORD_SIZE)) u_alu (
        .a_i  (alu_data0),
        .b_i  (alu_data1),
        .op_i (cw[3:0]),
        .y_o  (alu_y)
    );

    mulxx_pipe #(.WORD_SIZE(WORD_SIZE), .MUL_LATENCY(MUL_LATENCY)) u_mul (
        .clock    (clock),
        .reset    (reset),
        .start_i  (mul_start),
        .a_i      (alu_data0),
        .b_i      (alu_data1),
        .shift_i  (cw[4:0]),
        .wb_o     (mul_wb),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        wa_d    = '0;
        wd_d    = '0;
        jv_d    = 1'b0;
        ja_d    = '0;
        case (state_q)
            MUL:     state_d = mul_done ? RUN : MUL;
            WAIT:    state_d = wake ? RUN : WAIT;
            default: state_d = !accept ? RUN : (op == OP_MUL_SHIFT) ? MUL : (op == OP_WAIT) ? WAIT : RUN;
        endcase
        if (accept) begin
            case (op)
                OP_ADD_IMM8: begin
                    we_d = 1'b1;
                    wa_d = rx;
                    wd_d = data1_plus_imm8;
                end
                OP_MOV_IMM11: begin
                    we_d = 1'b1;
                    wa_d = rx;
                    wd_d = {{(WORD_SIZE-11){cw[10]}}, cw[10:0]};
                end
                OP_MOV_IMM11_TOP: begin
                    we_d = 1'b1;
                    wa_d = rx;
                    wd_d = WORD_SIZE'({cw[10:0], 7'b0});
                end
                OP_LOAD_FROM_MEMORY: begin
                    we_d = 1'b1;
                    wa_d = rx;
                    wd_d = memory_out;
                end
                OP_ALU: begin
                    we_d = 1'b1;
                    wa_d = rx;
                    wd_d = alu_y;
                end
                OP_IF: begin
                    jv_d = cond_true;
                    ja_d = cond_true ? if_target : '0;
                end
                OP_CALL_IMM14: begin
                    jv_d = 1'b1;
                    ja_d = ADDR_SIZE'(cw[13:0]);
                    we_d = 1'b1;
                    wa_d = 3'd7;
                    wd_d = WORD_SIZE'(ip_plus_one);
                end
                OP_RETURN: begin
                    jv_d = 1'b1;
                    ja_d = memory_out[ADDR_SIZE-1:0];
                end
                default: ;
            endcase
        end
        // Never overlaps another write: with latency 1 the accepted op is the MUL itself.
        if (mul_wb) begin
            we_d = 1'b1;
            wa_d = mul_start ? rx : mul_rx_q;
            wd_d = mul_res;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            jv_q     <= 1'b0;
            ja_q     <= '0;
            mul_rx_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            jv_q    <= jv_d;
            ja_q    <= ja_d;
            if (mul_start) mul_rx_q <= rx;
        end
    end

    assign reg_write_enable = we_q;
    assign reg_write_addr   = wa_q;
    assign reg_write_data   = wd_q;
    assign jump_valid       = jv_q;
    assign jump_addr        = ja_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// tb_exec_writeback_stage: scoreboard bench; stimulus pushes expected
// writeback/jump events (with the cycle they must appear in) and a negedge
// monitor pops and compares them whenever the DUT pulses an output.
module tb_exec_writeback_stage;
    import exec_writeback_stage_pkg::*;

    logic        clock = 1'b0, reset = 1'b0, in_valid = 1'b0, wake = 1'b0;
    logic [17:0] alu_data0 = '0, alu_data1 = '0, data1_plus_imm8 = '0, memory_out = '0;
    logic [17:0] code_word = '0, ip = '0, ip_plus_one = '0;
    logic        in_ready, reg_write_enable, jump_valid, busy;
    logic [2:0]  reg_write_addr;
    logic [17:0] reg_write_data, jump_addr;

    exec_writeback_stage #(.ADDR_SIZE(18), .WORD_SIZE(18), .MUL_LATENCY(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_data0        (alu_data0),
        .alu_data1        (alu_data1),
        .data1_plus_imm8  (data1_plus_imm8),
        .memory_out       (memory_out),
        .code_word        (code_word),
        .ip               (ip),
        .ip_plus_one      (ip_plus_one),
        .wake             (wake),
        .reg_write_enable (reg_write_enable),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .jump_valid       (jump_valid),
        .jump_addr        (jump_addr),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0, checks = 0, errors = 0, acc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int c; logic [2:0] a; logic [17:0] d; } wr_t;
    typedef struct { int c; logic [17:0] a; } jp_t;
    wr_t wq[$];
    jp_t jq[$];
    wr_t we;
    jp_t je;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic expw(input int off, input logic [2:0] a, input logic [17:0] d);
        wq.push_back('{acc + off, a, d});
    endtask

    task automatic expj(input int off, input logic [17:0] a);
        jq.push_back('{acc + off, a});
    endtask

    task automatic issue_now(input logic [17:0] cw);
        chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        code_word = cw;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic issue(input logic [17:0] cw);
        @(negedge clock);
        issue_now(cw);
    endtask

    always @(negedge clock) begin
        if (reg_write_enable) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got r%0d=%h expected no write (cycle %0d)", reg_write_addr, reg_write_data, cyc);
            end else begin
                we = wq.pop_front();
                chk("wr_cycle", cyc, we.c);
                chk("wr_addr", {29'd0, reg_write_addr}, {29'd0, we.a});
                chk("wr_data", {14'd0, reg_write_data}, {14'd0, we.d});
            end
        end
        if (jump_valid) begin
            if (jq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL jump_unexpected: got %h expected no jump (cycle %0d)", jump_addr, cyc);
            end else begin
                je = jq.pop_front();
                chk("jump_cycle", cyc, je.c);
                chk("jump_addr", {14'd0, jump_addr}, {14'd0, je.a});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_we", {31'd0, reg_write_enable}, 32'd0);
        chk("rst_jv", {31'd0, jump_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wdata", {11'd0, reg_write_addr, reg_write_data}, 32'd0);
        chk("rst_jaddr", {14'd0, jump_addr}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue({OP_MOV_IMM11, 3'd3, 11'h7FF});         expw(0, 3'd3, 18'h3FFFF);
        issue({OP_MOV_IMM11, 3'd0, 11'h123});         expw(0, 3'd0, 18'h00123);
        issue({OP_MOV_IMM11_TOP, 3'd1, 11'h401});     expw(0, 3'd1, 18'h20080);
        data1_plus_imm8 = 18'h12345;
        issue({OP_ADD_IMM8, 3'd5, 11'h000});          expw(0, 3'd5, 18'h12345);
        memory_out = 18'h2A5A5;
        issue({OP_LOAD_FROM_MEMORY, 3'd6, 11'h000});  expw(0, 3'd6, 18'h2A5A5);
        alu_data0 = 18'h3FFFF; alu_data1 = 18'h00001;
        issue({OP_ALU, 3'd2, 7'd0, ALU_ADD});         expw(0, 3'd2, 18'h00000);
        alu_data0 = 18'h00005; alu_data1 = 18'h00007;
        issue({OP_ALU, 3'd2, 7'd0, ALU_SUB});         expw(0, 3'd2, 18'h3FFFE);
        issue({OP_WRITE_TO_MEMORY, 3'd4, 11'h055});
        issue({4'hF, 14'h3FFF});

        alu_data0 = 18'h00005; ip = 18'h00010;
        issue({OP_IF, 3'd0, IF_NONZERO, 8'hF0});      expj(0, 18'h00000);
        alu_data0 = 18'h00000;
        issue({OP_IF, 3'd0, IF_NONZERO, 8'hF0});
        alu_data0 = 18'h20000; ip = 18'h3FFFF;
        issue({OP_IF, 3'd0, IF_NEG, 8'h02});          expj(0, 18'h00001);
        alu_data0 = 18'h00000;
        issue({OP_IF, 3'd0, 3'd7, 8'h02});
        ip = 18'h00100;
        issue({OP_IF, 3'd0, IF_ZERO, 8'h7F});         expj(0, 18'h0017F);

        ip_plus_one = 18'h00041;
        issue({OP_CALL_IMM14, 14'h1234});             expj(0, 18'h01234); expw(0, 3'd7, 18'h00041);
        memory_out = 18'h2ABCD;
        issue({OP_RETURN, 14'h0000});                 expj(0, 18'h2ABCD);

        alu_data0 = 18'h00100; alu_data1 = 18'h00200;
        issue({OP_MUL_SHIFT, 3'd4, 6'd0, 5'd4});      expw(2, 3'd4, 18'h02000);
        alu_data0 = 18'h1F0F0; alu_data1 = 18'h0ABCD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("mul_ready_low", {31'd0, in_ready}, 32'd0);
            chk("mul_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clock);
        chk("mul_ready_back", {31'd0, in_ready}, 32'd1);

        alu_data0 = 18'h3FFFF; alu_data1 = 18'h3FFFF;
        issue({OP_MUL_SHIFT, 3'd1, 6'd0, 5'd18});     expw(2, 3'd1, 18'h3FFFE);
        alu_data0 = 18'h00000; alu_data1 = 18'h00000;
        repeat (3) @(negedge clock);

        issue({OP_WAIT, 14'h0000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("wait_busy", {31'd0, busy}, 32'd1);
            chk("wait_ready_low", {31'd0, in_ready}, 32'd0);
            if (i == 4) wake = 1'b1;
        end
        @(negedge clock);
        chk("wait_done_busy", {31'd0, busy}, 32'd0);
        chk("wait_done_ready", {31'd0, in_ready}, 32'd1);
        wake = 1'b0;

        wake = 1'b1;
        issue({OP_WAIT, 14'h0000});
        @(negedge clock);
        chk("wake_at_accept_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        chk("wake_at_accept_clear", {31'd0, busy}, 32'd0);
        chk("wake_at_accept_ready", {31'd0, in_ready}, 32'd1);
        wake = 1'b0;

        alu_data0 = 18'h00100; alu_data1 = 18'h00200;
        issue({OP_MUL_SHIFT, 3'd5, 6'd0, 5'd4});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_outs", {12'd0, reg_write_enable, jump_valid, reg_write_data}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        issue_now({OP_MOV_IMM11, 3'd0, 11'h001});     expw(0, 3'd0, 18'h00001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("post_abort_busy", {31'd0, busy}, 32'd0);
        end

        chk("wq_drained", wq.size(), 32'd0);
        chk("jq_drained", jq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
